// File: rtl/axis_fork_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_fork_ctrl_pkg : state encoding and header field positions
// Rev 1.0
// ----------------------------------------------------------------------------
package axis_fork_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_PASS = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam int HDR_MASK_LSB = 0;

  // The mode bit sits directly above the destination mask.
  function automatic int hdr_mode_bit(input int m_count);
    return HDR_MASK_LSB + m_count;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fork_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_fork_ctrl_if : AXI-Stream data/handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface axis_fork_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_fork_ctrl_hdr_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_fork_ctrl_hdr_decode : routing header -> effective mask, mode, empty flag
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_fork_ctrl_hdr_decode
  import axis_fork_ctrl_pkg::*;
#(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] hdr_i,
  input  logic [M_COUNT-1:0]    port_en_i,
  output logic [M_COUNT-1:0]    emask_o,
  output logic                  mode_o,
  output logic                  empty_o
);

  localparam int HDR_MODE_BIT = hdr_mode_bit(M_COUNT);

  assign emask_o = hdr_i[HDR_MASK_LSB +: M_COUNT] & port_en_i;
  assign mode_o  = hdr_i[HDR_MODE_BIT];
  assign empty_o = (emask_o == '0);

  // Header bits above the mode bit carry no meaning for routing.
  generate
    if (DATA_WIDTH > HDR_MODE_BIT + 1) begin : g_unused_hdr
      logic unused_hdr_bits;
      assign unused_hdr_bits = ^hdr_i[DATA_WIDTH-1:HDR_MODE_BIT+1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/axis_fork_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_fork_ctrl : consumes a routing header per frame and drives fork arbiter controls
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_fork_ctrl
  import axis_fork_ctrl_pkg::*;
#(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [M_COUNT-1:0]   cfg_port_en,
  axis_fork_ctrl_if.slave      s_axis,
  axis_fork_ctrl_if.master     m_axis,
  output logic [M_COUNT-1:0]   oen,
  output logic                 fork_enable,
  output logic [M_COUNT-1:0]   single_mask,
  output logic                 frame_done,
  output logic                 frame_drop,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  state_e               state_q, state_d;
  logic [M_COUNT-1:0]   emask_q;
  logic                 mode_q;
  logic                 empty_q;
  logic [M_COUNT-1:0]   oen_q;
  logic                 fork_q;
  logic [M_COUNT-1:0]   single_q;
  logic                 done_q, drop_q;
  logic [CNT_WIDTH-1:0] fcnt_q, dcnt_q;

  logic [M_COUNT-1:0]   hdr_emask;
  logic                 hdr_mode, hdr_empty;
  logic                 s_ready, m_valid;
  logic                 done_set, drop_set, hdr_take;

  axis_fork_ctrl_hdr_decode #(
    .M_COUNT    (M_COUNT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hdr_decode (
    .hdr_i     (s_axis.tdata),
    .port_en_i (cfg_port_en),
    .emask_o   (hdr_emask),
    .mode_o    (hdr_mode),
    .empty_o   (hdr_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (hdr_take) state_d = ST_CFG;
      ST_CFG:  state_d = empty_q ? ST_DROP : ST_PASS;
      ST_PASS: if (done_set) state_d = ST_IDLE;
      ST_DROP: if (drop_set) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A header carrying tlast is a complete (empty) frame and is dropped in place.
  always_comb begin
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    done_set = 1'b0;
    drop_set = 1'b0;
    hdr_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_ready  = 1'b1;
        hdr_take = s_axis.tvalid & ~s_axis.tlast;
        drop_set = s_axis.tvalid &  s_axis.tlast;
      end
      ST_CFG: ;
      ST_PASS: begin
        s_ready  = m_axis.tready;
        m_valid  = s_axis.tvalid;
        done_set = s_axis.tvalid & m_axis.tready & s_axis.tlast;
      end
      ST_DROP: begin
        s_ready  = 1'b1;
        drop_set = s_axis.tvalid & s_axis.tlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emask_q  <= '0;
      mode_q   <= 1'b0;
      empty_q  <= 1'b1;
      oen_q    <= '0;
      fork_q   <= 1'b0;
      single_q <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      if (hdr_take) begin
        emask_q <= hdr_emask;
        mode_q  <= hdr_mode;
        empty_q <= hdr_empty;
      end
      // Arbiter controls only move in CFG, between frames.
      if (state_q == ST_CFG) begin
        oen_q    <= emask_q;
        fork_q   <= mode_q;
        single_q <= mode_q ? '0 : emask_q;
      end
      done_q <= done_set;
      drop_q <= drop_set;
      if (done_set) fcnt_q <= fcnt_q + 1'b1;
      if (drop_set && (dcnt_q != '1)) dcnt_q <= dcnt_q + 1'b1;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tlast  = s_axis.tlast;

  assign oen         = oen_q;
  assign fork_enable = fork_q;
  assign single_mask = single_q;
  assign frame_done  = done_q;
  assign frame_drop  = drop_q;
  assign frame_cnt   = fcnt_q;
  assign drop_cnt    = dcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_fork_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axis_fork_ctrl : directed table, corner sequences and randomized frames
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_fork_ctrl;

  localparam int M_COUNT    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = 8;
  localparam int CNT_MAX    = 255;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [M_COUNT-1:0]   cfg_port_en = '0;
  logic [M_COUNT-1:0]   oen, single_mask;
  logic                 fork_enable, frame_done, frame_drop;
  logic [CNT_WIDTH-1:0] frame_cnt, drop_cnt;

  axis_fork_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) s_if ();
  axis_fork_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) m_if ();

  axis_fork_ctrl #(
    .M_COUNT    (M_COUNT),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_port_en (cfg_port_en),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .oen         (oen),
    .fork_enable (fork_enable),
    .single_mask (single_mask),
    .frame_done  (frame_done),
    .frame_drop  (frame_drop),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  typedef struct {
    logic [3:0] dmask;
    logic       mode;
    logic [3:0] cfg;
    int         nbeats;
    logic       hdr_only;
    logic [3:0] exp_oen;
    logic       exp_fork;
    logic [3:0] exp_single;
    logic       exp_fwd;
  } vec_t;

  vec_t tbl[7];

  // Expected DUT state held by the bench
  logic [3:0] cur_oen = '0, cur_single = '0;
  logic       cur_fork = 1'b0;
  int         exp_frames = 0, exp_drops = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    #1;
    chk("rst_oen", oen, 0);
    chk("rst_fork", fork_enable, 0);
    chk("rst_single", single_mask, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_drop", frame_drop, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_m_valid", m_if.tvalid, 0);
    chk("rst_s_ready", s_if.tready, 1);
    cur_oen = '0; cur_single = '0; cur_fork = 1'b0;
    exp_frames = 0; exp_drops = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    cfg_port_en = v.cfg;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {11'($urandom), v.mode, v.dmask};
    s_if.tlast  = v.hdr_only;
    #1;
    chk($sformatf("v%0d_hdr_ready", idx), s_if.tready, 1);
    tick();
    if (v.hdr_only) begin
      s_if.tvalid = 1'b0;
      #1;
      exp_drops++;
      chk($sformatf("v%0d_drop_pulse", idx), frame_drop, 1);
      chk($sformatf("v%0d_done_pulse", idx), frame_done, 0);
      chk($sformatf("v%0d_drop_cnt", idx), drop_cnt, sat(exp_drops));
      chk($sformatf("v%0d_oen_kept", idx), oen, v.exp_oen);
      chk($sformatf("v%0d_fork_kept", idx), fork_enable, v.exp_fork);
      chk($sformatf("v%0d_single_kept", idx), single_mask, v.exp_single);
    end else begin
      // CFG cycle: first payload beat offered but must not be taken
      s_if.tdata = 16'(16'hA000 + (idx << 4));
      s_if.tlast = (v.nbeats == 1);
      #1;
      chk($sformatf("v%0d_cfg_ready", idx), s_if.tready, 0);
      chk($sformatf("v%0d_cfg_mvalid", idx), m_if.tvalid, 0);
      chk($sformatf("v%0d_cfg_oen_old", idx), oen, cur_oen);
      tick();
      cur_oen = v.exp_oen; cur_fork = v.exp_fork; cur_single = v.exp_single;
      for (int b = 0; b < v.nbeats; b++) begin
        s_if.tdata = 16'(16'hA000 + (idx << 4) + b);
        s_if.tlast = (b == v.nbeats - 1);
        #1;
        chk($sformatf("v%0d_b%0d_oen", idx, b), oen, cur_oen);
        chk($sformatf("v%0d_b%0d_fork", idx, b), fork_enable, cur_fork);
        chk($sformatf("v%0d_b%0d_single", idx, b), single_mask, cur_single);
        chk($sformatf("v%0d_b%0d_mvalid", idx, b), m_if.tvalid, v.exp_fwd);
        chk($sformatf("v%0d_b%0d_sready", idx, b), s_if.tready, 1);
        chk($sformatf("v%0d_b%0d_pulses", idx, b), {frame_done, frame_drop}, 0);
        if (v.exp_fwd) begin
          chk($sformatf("v%0d_b%0d_mdata", idx, b), m_if.tdata, 16'(16'hA000 + (idx << 4) + b));
          chk($sformatf("v%0d_b%0d_mlast", idx, b), m_if.tlast, (b == v.nbeats - 1));
        end
        tick();
      end
      s_if.tvalid = 1'b0;
      #1;
      if (v.exp_fwd) exp_frames++;
      else           exp_drops++;
      chk($sformatf("v%0d_done", idx), frame_done, v.exp_fwd);
      chk($sformatf("v%0d_drop", idx), frame_drop, !v.exp_fwd);
      chk($sformatf("v%0d_frame_cnt", idx), frame_cnt, exp_frames % (CNT_MAX + 1));
      chk($sformatf("v%0d_drop_cnt", idx), drop_cnt, sat(exp_drops));
      chk($sformatf("v%0d_idle_ready", idx), s_if.tready, 1);
    end
  endtask

  // One-beat forwarded frame, fork to port 0, at full rate
  task automatic quick_frame();
    s_if.tvalid = 1'b1;
    s_if.tdata  = 16'h0011;
    s_if.tlast  = 1'b0;
    tick();
    s_if.tdata  = 16'hBEEF;
    s_if.tlast  = 1'b1;
    tick();
    tick();
    s_if.tvalid = 1'b0;
  endtask

  // Randomized frames and the frame-level reference model
  typedef struct { logic [3:0] dmask; logic mode; logic hdr_only; int nbeats; } frm_t;
  typedef struct { logic [15:0] data; logic last; logic is_hdr; int fidx; } beat_t;
  typedef struct { logic [15:0] data; logic last; logic [3:0] oen; logic fk; logic [3:0] sm; } exp_t;

  task automatic random_phase();
    frm_t  frames[$];
    beat_t src[$];
    exp_t  exq[$];
    int    r_fwd = 0, r_drops = 0, n_done = 0, n_drop = 0, n_both = 0, tail = 0;
    bit    holding = 0, finished = 0;
    for (int f = 0; f < 80; f++) begin
      frm_t fr;
      fr.dmask    = 4'($urandom);
      fr.mode     = 1'($urandom);
      fr.hdr_only = (($urandom % 8) == 0);
      fr.nbeats   = fr.hdr_only ? 0 : int'($urandom_range(1, 5));
      frames.push_back(fr);
      src.push_back('{{11'($urandom), fr.mode, fr.dmask}, fr.hdr_only, 1'b1, f});
      for (int k = 0; k < fr.nbeats; k++)
        src.push_back('{{8'(f), 8'(k)}, (k == fr.nbeats - 1), 1'b0, f});
    end
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      cfg_port_en = 4'($urandom);
      m_if.tready = (($urandom % 3) != 0);
      if (!holding && src.size() > 0 && (($urandom % 4) != 0)) begin
        s_if.tdata = src[0].data;
        s_if.tlast = src[0].last;
        holding    = 1'b1;
      end
      s_if.tvalid = holding;
      #1;
      if (frame_done) n_done++;
      if (frame_drop) n_drop++;
      if (frame_done && frame_drop) n_both++;
      if (m_if.tvalid && m_if.tready) begin
        if (exq.size() == 0) begin
          chk("rnd_unexpected_beat", m_if.tdata, 0);
        end else begin
          exp_t e = exq.pop_front();
          chk("rnd_data", m_if.tdata, e.data);
          chk("rnd_last", m_if.tlast, e.last);
          chk("rnd_oen", oen, e.oen);
          chk("rnd_fork", fork_enable, e.fk);
          chk("rnd_single", single_mask, e.sm);
        end
      end
      if (s_if.tvalid && s_if.tready) begin
        beat_t b = src.pop_front();
        holding = 1'b0;
        if (b.is_hdr) begin
          frm_t fr = frames[b.fidx];
          logic [3:0] em = fr.dmask & cfg_port_en;
          if (fr.hdr_only || em == 4'd0) begin
            r_drops++;
          end else begin
            r_fwd++;
            for (int k = 0; k < fr.nbeats; k++)
              exq.push_back('{{8'(b.fidx), 8'(k)}, (k == fr.nbeats - 1), em, fr.mode,
                              fr.mode ? 4'd0 : em});
          end
        end
      end
      if (src.size() == 0 && exq.size() == 0 && !holding) begin
        tail++;
        if (tail > 3) finished = 1'b1;
      end
      tick();
    end
    s_if.tvalid = 1'b0;
    #1;
    chk("rnd_finished", finished, 1);
    chk("rnd_leftover", exq.size(), 0);
    chk("rnd_done_pulses", n_done, r_fwd);
    chk("rnd_drop_pulses", n_drop, r_drops);
    chk("rnd_both_pulses", n_both, 0);
    chk("rnd_frame_cnt", frame_cnt, r_fwd % (CNT_MAX + 1));
    chk("rnd_drop_cnt", drop_cnt, sat(r_drops));
  endtask

  initial begin
    tbl[0] = '{4'b1011, 1'b1, 4'b1111, 3, 1'b0, 4'b1011, 1'b1, 4'b0000, 1'b1};
    tbl[1] = '{4'b0110, 1'b0, 4'b0100, 2, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[2] = '{4'b0001, 1'b0, 4'b1110, 4, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[3] = '{4'b1111, 1'b1, 4'b1111, 0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[4] = '{4'b1111, 1'b1, 4'b0101, 1, 1'b0, 4'b0101, 1'b1, 4'b0000, 1'b1};
    tbl[5] = '{4'b0011, 1'b0, 4'b1111, 0, 1'b1, 4'b0101, 1'b1, 4'b0000, 1'b0};
    tbl[6] = '{4'b1001, 1'b0, 4'b1111, 2, 1'b0, 4'b1001, 1'b0, 4'b1001, 1'b1};

    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Counter limits: drops saturate, forwarded frames wrap
    do_reset();
    cfg_port_en = 4'b1111;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b1;
    s_if.tdata  = 16'h001F;
    repeat (300) tick();
    s_if.tvalid = 1'b0;
    #1;
    chk("sat_drop_cnt", drop_cnt, CNT_MAX);
    chk("sat_oen_kept", oen, 0);
    for (int i = 0; i < CNT_MAX; i++) quick_frame();
    #1;
    chk("wrap_frame_cnt_max", frame_cnt, CNT_MAX);
    quick_frame();
    #1;
    chk("wrap_frame_cnt_zero", frame_cnt, 0);
    chk("wrap_drop_cnt_held", drop_cnt, CNT_MAX);
    chk("wrap_oen", oen, 4'b0001);
    chk("wrap_fork", fork_enable, 1);

    // Reset asserted while a payload beat is stalled in PASS
    cfg_port_en = 4'b1111;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 16'h000A;
    s_if.tlast  = 1'b0;
    tick();
    s_if.tdata  = 16'h5555;
    s_if.tlast  = 1'b1;
    tick();
    tick();
    #1;
    chk("midrst_pass_mvalid", m_if.tvalid, 1);
    chk("midrst_pass_single", single_mask, 4'b1010);
    do_reset();
    run_vec(0, tbl[0]);

    do_reset();
    random_phase();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
